matmul_tile_scheduler: RTL and testbench
========================================

Name: matmul_tile_scheduler

Overview:
- Sequences a blocked matrix multiply C[M][N] = A[M][K] * B[K][N] by issuing one tile task per (m-block, n-block, k-block) to the multiply/accumulate datapath.
- Uses a valid/ready handshake and bounds the number of outstanding tasks with a completion-credit counter.
- Asserts a one-cycle done pulse once every task has been issued and completed.
- Sits between the top-level start control and the tile compute engine.

Parameters:
- M, 21, rows of A and C.
- N, 21, columns of B and C.
- K, 21, inner dimension.
- M_BLOCK_SIZE, 3, tile rows.
- N_BLOCK_SIZE, 1, tile columns.
- K_BLOCK_SIZE, 3, tile inner depth.
- IDX_W, 8, width of index and length fields; must hold max(M,N,K).
- MAX_INFLIGHT, 4, maximum issued-but-uncompleted tasks (≥1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  begin a full multiply; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when all tasks have completed.
- task_valid  out  1  task fields are valid.
- task_ready  in  1  compute engine accepts the task.
- task_m  out  IDX_W  row base of the tile.
- task_n  out  IDX_W  column base of the tile.
- task_k  out  IDX_W  inner base of the tile.
- task_m_len  out  IDX_W  tile rows, min(M_BLOCK_SIZE, M-task_m).
- task_n_len  out  IDX_W  tile columns, min(N_BLOCK_SIZE, N-task_n).
- task_k_len  out  IDX_W  tile depth, min(K_BLOCK_SIZE, K-task_k).
- task_first_k  out  1  task_k==0: engine clears the accumulator.
- task_last_k  out  1  task_k+task_k_len==K: engine writes back C.
- cmpl_valid  in  1  one-cycle pulse per completed task.
- inflight  out  clog2(MAX_INFLIGHT+1)  outstanding task count.
- err  out  1  sticky flag: completion received with inflight==0.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. A reset in the middle of an operation abandons the job immediately. No done pulse is produced.
- Fire: task_valid && task_ready on a rising edge.
- Loop order: k innermost, then n, then m outermost. Each base advances by its block size. The last block of a dimension is ragged, with len = dim - base.
- Total tasks: ceil(M/Mb)*ceil(N/Nb)*ceil(K/Kb).
- IDLE:
  - start=1 → ISSUE.
  - Bases are cleared to 0.
  - busy rises on the next cycle.
  - task_valid may first be high in the cycle after start is sampled.
- ISSUE:
  - task_valid = (inflight < MAX_INFLIGHT), or (inflight == MAX_INFLIGHT and cmpl_valid), i.e. a credit freed in the same cycle.
  - All task fields are registered.
  - While task_valid && !task_ready, the fields hold stable and task_valid does not drop.
  - On fire: advance to the next tile. If the fired tile was the last → DRAIN and task_valid drops the next cycle.
- DRAIN: wait until inflight==0, including a final completion arriving this cycle → DONE.
- DONE: done=1 for exactly one cycle, busy=0 that same cycle → IDLE.
- inflight: +1 on fire, -1 on cmpl_valid. Fire and completion in the same cycle leave it unchanged.
- cmpl_valid with inflight==0 and no fire in that cycle sets err (cleared only by rst). inflight does not underflow.
- start while not in IDLE is ignored.
- Throughput: one task per cycle while task_ready=1 and credit is available. Back-to-back fires have no bubble.
- Degenerate case: block size ≥ dimension gives one block with len=dim.

Test Plan:
1. Defaults (21/21/21, blocks 3,1,3), task_ready=1, cmpl_valid echoes each fire 2 cycles later:
   - Exactly 7*21*7 = 1029 fires.
   - First task (0,0,0) has first_k=1 and last_k=0; task k=18 has last_k=1.
   - done pulses once, with inflight=0 at that point.
2. M=5, N=3, K=4, blocks 2,3,3:
   - task_m_len sequence 2,2,1.
   - task_k_len sequence 3,1.
   - 6 tasks total; ordering k-inner verified against a golden list.
3. Backpressure: random task_ready (50%) → fields are stable across every stall cycle and no tile is skipped or duplicated.
4. Credit limit: MAX_INFLIGHT=4, completions withheld:
   - Exactly 4 fires, then task_valid=0.
   - A single cmpl_valid re-enables issue in the same cycle.
   - Simultaneous fire+cmpl holds inflight=4.
5. Reset mid-operation: rst after 10 fires → next cycle busy=0, task_valid=0, inflight=0. A fresh start then restarts at (0,0,0).
6. Spurious cmpl_valid in IDLE → err=1 and inflight stays 0. start pulsed while busy is ignored (tile count unchanged).

Source files
------------

// File: rtl/matmul_tile_scheduler_if.sv
// Tile task issue channel plus the completion return from the compute engine.
interface matmul_tile_scheduler_if #(
    parameter int unsigned IDX_W = 8
);
    logic             task_valid;
    logic             task_ready;
    logic [IDX_W-1:0] task_m;
    logic [IDX_W-1:0] task_n;
    logic [IDX_W-1:0] task_k;
    logic [IDX_W-1:0] task_m_len;
    logic [IDX_W-1:0] task_n_len;
    logic [IDX_W-1:0] task_k_len;
    logic             task_first_k;
    logic             task_last_k;
    logic             cmpl_valid;

    // Scheduler side: issues tasks, receives completions.
    modport master (
        output task_valid, task_m, task_n, task_k,
               task_m_len, task_n_len, task_k_len,
               task_first_k, task_last_k,
        input  task_ready, cmpl_valid
    );

    // Compute engine side.
    modport slave (
        input  task_valid, task_m, task_n, task_k,
               task_m_len, task_n_len, task_k_len,
               task_first_k, task_last_k,
        output task_ready, cmpl_valid
    );
endinterface

// File: rtl/matmul_tile_scheduler.sv
// Walks the (m, n, k) tile space of a blocked matrix multiply, k innermost,
// issuing one task per tile with a completion-credit limit on outstanding work.
module matmul_tile_scheduler #(
    parameter int unsigned M            = 21,
    parameter int unsigned N            = 21,
    parameter int unsigned K            = 21,
    parameter int unsigned M_BLOCK_SIZE = 3,
    parameter int unsigned N_BLOCK_SIZE = 1,
    parameter int unsigned K_BLOCK_SIZE = 3,
    parameter int unsigned IDX_W        = 8,
    parameter int unsigned MAX_INFLIGHT = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    output logic                                 busy,
    output logic                                 done,
    matmul_tile_scheduler_if.master              tile,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0]    inflight,
    output logic                                 err
);

    localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1);
    // One extra bit so base + block never wraps before comparing to the dimension.
    localparam int unsigned SW    = IDX_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    state_t           state;
    logic             fire;
    logic             load;
    logic             k_wrap;
    logic             n_wrap;
    logic             m_wrap;
    logic             tile_last;
    logic [SW-1:0]    k_end;
    logic [SW-1:0]    n_end;
    logic [SW-1:0]    m_end;
    logic [IDX_W-1:0] nxt_m;
    logic [IDX_W-1:0] nxt_n;
    logic [IDX_W-1:0] nxt_k;
    logic [CNT_W-1:0] inflight_nxt;

    // Length of the tile starting at base: full block, or the ragged remainder.
    function automatic logic [IDX_W-1:0] blk_len(input logic [IDX_W-1:0] base,
                                                 input int unsigned      dim,
                                                 input int unsigned      bsz);
        logic [SW-1:0] rem;
        rem = SW'(dim) - SW'(base);
        return (rem > SW'(bsz)) ? IDX_W'(bsz) : rem[IDX_W-1:0];
    endfunction

    // A credit freed by a completion this cycle can be spent immediately.
    assign tile.task_valid = (state == ISSUE) &&
                             ((inflight < CNT_W'(MAX_INFLIGHT)) || tile.cmpl_valid);
    assign fire = tile.task_valid && tile.task_ready;
    assign load = ((state == IDLE) && start) || fire;

    // Next tile coordinates: k advances every task, n on k wrap, m on n wrap.
    always_comb begin
        k_end     = SW'(tile.task_k) + SW'(K_BLOCK_SIZE);
        n_end     = SW'(tile.task_n) + SW'(N_BLOCK_SIZE);
        m_end     = SW'(tile.task_m) + SW'(M_BLOCK_SIZE);
        k_wrap    = k_end >= SW'(K);
        n_wrap    = n_end >= SW'(N);
        m_wrap    = m_end >= SW'(M);
        tile_last = k_wrap && n_wrap && m_wrap;
        nxt_m     = '0;
        nxt_n     = '0;
        nxt_k     = '0;
        if (state != IDLE) begin
            nxt_k = k_wrap ? '0 : k_end[IDX_W-1:0];
            nxt_n = k_wrap ? (n_wrap ? '0 : n_end[IDX_W-1:0]) : tile.task_n;
            nxt_m = (k_wrap && n_wrap) ? (m_wrap ? '0 : m_end[IDX_W-1:0]) : tile.task_m;
        end
    end

    // Outstanding count: a fire and a completion in the same cycle cancel; never underflows.
    always_comb begin
        inflight_nxt = inflight;
        if (fire && !tile.cmpl_valid) begin
            inflight_nxt = inflight + CNT_W'(1);
        end else if (!fire && tile.cmpl_valid && (inflight != '0)) begin
            inflight_nxt = inflight - CNT_W'(1);
        end
    end

    // Control FSM, task field registers, credit counter and error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            busy              <= 1'b0;
            done              <= 1'b0;
            inflight          <= '0;
            err               <= 1'b0;
            tile.task_m       <= '0;
            tile.task_n       <= '0;
            tile.task_k       <= '0;
            tile.task_m_len   <= '0;
            tile.task_n_len   <= '0;
            tile.task_k_len   <= '0;
            tile.task_first_k <= 1'b0;
            tile.task_last_k  <= 1'b0;
        end else begin
            done     <= 1'b0;
            inflight <= inflight_nxt;
            if (tile.cmpl_valid && (inflight == '0) && !fire) begin
                err <= 1'b1;
            end
            if (load) begin
                tile.task_m       <= nxt_m;
                tile.task_n       <= nxt_n;
                tile.task_k       <= nxt_k;
                tile.task_m_len   <= blk_len(nxt_m, M, M_BLOCK_SIZE);
                tile.task_n_len   <= blk_len(nxt_n, N, N_BLOCK_SIZE);
                tile.task_k_len   <= blk_len(nxt_k, K, K_BLOCK_SIZE);
                tile.task_first_k <= (nxt_k == '0);
                tile.task_last_k  <= (SW'(nxt_k) + SW'(K_BLOCK_SIZE)) >= SW'(K);
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= ISSUE;
                        busy  <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (fire && tile_last) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (inflight_nxt == '0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_tile_scheduler.sv
// Bench for matmul_tile_scheduler: two instances (default sizes and a small
// ragged configuration) checked against a nested-loop golden tile list.
module tb_matmul_tile_scheduler;

    typedef struct packed {
        logic [7:0] m;
        logic [7:0] n;
        logic [7:0] k;
        logic [7:0] ml;
        logic [7:0] nl;
        logic [7:0] kl;
        logic       fk;
        logic       lk;
    } tile_t;

    logic       clk;
    logic       rst;
    logic       sel;
    logic       start_a, start_b;
    logic       busy_a, busy_b, done_a, done_b, err_a, err_b;
    logic [2:0] inflight_a, inflight_b;

    logic       o_valid, o_busy, o_done, o_err;
    logic [2:0] o_inflight;
    tile_t      o_fields;

    int    passed;
    int    total_checks;
    int    exp_inflight;
    bit    exp_err;
    bit    prev_stall;
    tile_t held_fields;
    tile_t gq[$];

    matmul_tile_scheduler_if #(.IDX_W(8)) ifa ();
    matmul_tile_scheduler_if #(.IDX_W(8)) ifb ();

    matmul_tile_scheduler dut_a (
        .clk      (clk),
        .rst      (rst),
        .start    (start_a),
        .busy     (busy_a),
        .done     (done_a),
        .tile     (ifa),
        .inflight (inflight_a),
        .err      (err_a)
    );

    matmul_tile_scheduler #(
        .M(5), .N(3), .K(4),
        .M_BLOCK_SIZE(2), .N_BLOCK_SIZE(3), .K_BLOCK_SIZE(3),
        .IDX_W(8), .MAX_INFLIGHT(4)
    ) dut_b (
        .clk      (clk),
        .rst      (rst),
        .start    (start_b),
        .busy     (busy_b),
        .done     (done_b),
        .tile     (ifb),
        .inflight (inflight_b),
        .err      (err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign o_valid    = sel ? ifb.task_valid : ifa.task_valid;
    assign o_busy     = sel ? busy_b : busy_a;
    assign o_done     = sel ? done_b : done_a;
    assign o_err      = sel ? err_b : err_a;
    assign o_inflight = sel ? inflight_b : inflight_a;
    assign o_fields   = sel ?
        {ifb.task_m, ifb.task_n, ifb.task_k, ifb.task_m_len, ifb.task_n_len,
         ifb.task_k_len, ifb.task_first_k, ifb.task_last_k} :
        {ifa.task_m, ifa.task_n, ifa.task_k, ifa.task_m_len, ifa.task_n_len,
         ifa.task_k_len, ifa.task_first_k, ifa.task_last_k};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Golden tile order for the selected instance: m outer, n, k inner.
    task automatic build_golden(output int total);
        int md, nd, kd, mb, nb, kb;
        tile_t t;
        if (sel) begin md = 5;  nd = 3;  kd = 4;  mb = 2; nb = 3; kb = 3; end
        else     begin md = 21; nd = 21; kd = 21; mb = 3; nb = 1; kb = 3; end
        gq.delete();
        for (int m = 0; m < md; m += mb)
            for (int n = 0; n < nd; n += nb)
                for (int k = 0; k < kd; k += kb) begin
                    t.m  = 8'(m);
                    t.n  = 8'(n);
                    t.k  = 8'(k);
                    t.ml = 8'((md - m < mb) ? md - m : mb);
                    t.nl = 8'((nd - n < nb) ? nd - n : nb);
                    t.kl = 8'((kd - k < kb) ? kd - k : kb);
                    t.fk = (k == 0);
                    t.lk = (k + int'(t.kl) == kd);
                    gq.push_back(t);
                end
        total = ((md + mb - 1) / mb) * ((nd + nb - 1) / nb) * ((kd + kb - 1) / kb);
    endtask

    task automatic drive(input bit st, input bit rdy, input bit cm);
        start_a          = !sel && st;
        ifa.task_ready   = !sel && rdy;
        ifa.cmpl_valid   = !sel && cm;
        start_b          = sel && st;
        ifb.task_ready   = sel && rdy;
        ifb.cmpl_valid   = sel && cm;
    endtask

    // One clock: drive inputs, observe pre-edge outputs, update the reference model.
    task automatic step(input bit rs, input bit st, input bit rdy, input bit cm, output bit fired);
        tile_t exp_t;
        @(negedge clk);
        rst = rs;
        drive(st, rdy, cm);
        #1;
        if (prev_stall) begin
            check("stall_valid_held", 64'(o_valid), 64'(1));
            check("stall_fields_held", 64'(o_fields), 64'(held_fields));
        end
        check("inflight", 64'(o_inflight), 64'(exp_inflight));
        check("err", 64'(o_err), 64'(exp_err));
        fired = o_valid && rdy && !rs;
        if (fired) begin
            check("tile_available", 64'(gq.size() != 0), 64'(1));
            if (gq.size() != 0) begin
                exp_t = gq.pop_front();
                check("tile_fields", 64'(o_fields), 64'(exp_t));
            end
        end
        prev_stall  = o_valid && !rdy && !rs;
        held_fields = o_fields;
        if (rs) begin
            exp_inflight = 0;
            exp_err      = 1'b0;
            prev_stall   = 1'b0;
        end else begin
            if (cm && exp_inflight == 0 && !fired) exp_err = 1'b1;
            if (fired && !cm) exp_inflight++;
            else if (!fired && cm && exp_inflight != 0) exp_inflight--;
        end
    endtask

    // Full job with completions echoed two cycles after each fire.
    task automatic run_job(input int pct, input bit restarts, input int budget);
        int fires, cyc, first_c, last_c, total;
        bit f, fin, rdy, cm, st;
        bit [1:0] pipe;
        fires = 0; cyc = 0; first_c = -1; last_c = -1; fin = 1'b0; pipe = '0;
        build_golden(total);
        step(1'b0, 1'b1, 1'b0, 1'b0, f);
        check("idle_valid_low", 64'(o_valid), 64'(0));
        while (!fin && cyc < budget) begin
            rdy = int'($urandom_range(99, 0)) < pct;
            cm  = pipe[1];
            st  = restarts && cyc >= 5 && cyc <= 7;
            step(1'b0, st, rdy, cm, f);
            if (cyc == 0) begin
                check("valid_after_start", 64'(o_valid), 64'(1));
                check("busy_after_start", 64'(o_busy), 64'(1));
            end
            pipe = {pipe[0], f};
            if (f) begin
                if (first_c < 0) first_c = cyc;
                last_c = cyc;
                fires++;
            end
            if (o_done) begin
                check("done_inflight_zero", 64'(o_inflight), 64'(0));
                check("done_busy_low", 64'(o_busy), 64'(0));
                fin = 1'b1;
            end
            cyc++;
        end
        check("job_finished", 64'(fin), 64'(1));
        check("fire_count", 64'(fires), 64'(total));
        check("golden_drained", 64'(gq.size()), 64'(0));
        if (pct == 100) check("no_bubble", 64'(last_c - first_c + 1), 64'(fires));
        step(1'b0, 1'b0, 1'b0, 1'b0, f);
        check("done_single_pulse", 64'(o_done), 64'(0));
        check("idle_busy_low", 64'(o_busy), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  total, fires, cyc;
        bit  f;
        bit [1:0] pipe;
        passed = 0; total_checks = 0;
        exp_inflight = 0; exp_err = 1'b0; prev_stall = 1'b0; held_fields = '0;
        rst = 1'b1; sel = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);

        // Reset state of both instances.
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            check("rst_busy", 64'(o_busy), 64'(0));
            check("rst_done", 64'(o_done), 64'(0));
            check("rst_valid", 64'(o_valid), 64'(0));
            check("rst_inflight", 64'(o_inflight), 64'(0));
            check("rst_err", 64'(o_err), 64'(0));
        end

        // Default sizes, always ready: 1029 tiles, no bubbles.
        sel = 1'b0;
        run_job(100, 1'b0, 3000);

        // Small ragged configuration, then random backpressure on it.
        sel = 1'b1;
        run_job(100, 1'b0, 200);
        run_job(50, 1'b0, 400);

        // Credit limit with completions withheld.
        sel = 1'b0;
        build_golden(total);
        step(1'b0, 1'b1, 1'b0, 1'b0, f);
        fires = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, f);
            fires += int'(f);
        end
        check("credit_fires", 64'(fires), 64'(4));
        step(1'b0, 1'b0, 1'b1, 1'b0, f);
        check("credit_blocked", 64'(o_valid), 64'(0));
        check("credit_full", 64'(o_inflight), 64'(4));
        step(1'b0, 1'b0, 1'b1, 1'b1, f);
        check("credit_same_cycle", 64'(o_valid), 64'(1));
        step(1'b0, 1'b0, 1'b1, 1'b0, f);
        check("fire_cmpl_hold", 64'(o_inflight), 64'(4));
        check("credit_blocked_again", 64'(o_valid), 64'(0));
        step(1'b1, 1'b0, 1'b0, 1'b0, f);

        // Reset after 10 fires abandons the job.
        build_golden(total);
        step(1'b0, 1'b1, 1'b0, 1'b0, f);
        fires = 0; cyc = 0; pipe = '0;
        while (fires < 10 && cyc < 50) begin
            step(1'b0, 1'b0, 1'b1, pipe[1], f);
            pipe = {pipe[0], f};
            fires += int'(f);
            cyc++;
        end
        check("ten_fires", 64'(fires), 64'(10));
        step(1'b1, 1'b0, 1'b0, 1'b0, f);
        step(1'b0, 1'b0, 1'b0, 1'b0, f);
        check("midrst_busy", 64'(o_busy), 64'(0));
        check("midrst_valid", 64'(o_valid), 64'(0));
        check("midrst_inflight", 64'(o_inflight), 64'(0));
        check("midrst_done", 64'(o_done), 64'(0));

        // Fresh job restarts at tile 0 with backpressure and ignored start pulses.
        run_job(50, 1'b1, 6000);

        // Spurious completion while idle.
        step(1'b0, 1'b0, 1'b0, 1'b1, f);
        step(1'b0, 1'b0, 1'b0, 1'b0, f);
        check("spurious_err", 64'(o_err), 64'(1));
        check("spurious_inflight", 64'(o_inflight), 64'(0));
        step(1'b0, 1'b0, 1'b0, 1'b0, f);
        check("err_sticky", 64'(o_err), 64'(1));

        $display("%0d/%0d checks passed", passed, total_checks);
        $finish;
    end

endmodule
